// File: rtl/gem_cluster_sequencer.sv
// Latches up to 8 raw GEM clusters per BX and issues the valid ones one per clock, lowest slot first.
// Optional macro GEM_SEQ_ROLL_FILTER_EN adds a roll_mask input that suppresses clusters by eta partition.
module gem_cluster_sequencer #(
    parameter int          MXCLUSTERS    = 8,
    parameter logic [7:0]  PADS_PER_ROLL = 8'd192,
    parameter logic [10:0] MAXADR        = 11'd1535
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     bx_strobe,
    input  logic [14*MXCLUSTERS-1:0] clusters_in,
`ifdef GEM_SEQ_ROLL_FILTER_EN
    input  logic [7:0]               roll_mask,
`endif
    output logic [13:0]              cluster0,
    output logic                     cluster0_vpf,
    output logic [2:0]               cluster0_roll,
    output logic [7:0]               cluster0_pad,
    output logic [2:0]               cluster0_size,
    output logic [2:0]               cluster0_index,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic [7:0]               ndropped
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state;
    logic [MXCLUSTERS-1:0]   pending;
    logic [13:0]             lat_word [MXCLUSTERS];
    logic [13:0]             in_word  [MXCLUSTERS];
    logic [MXCLUSTERS-1:0]   new_mask;
    logic [2:0]              lat_idx;
    logic [2:0]              new_idx;
    logic [13:0]             lat_sel;
    logic [13:0]             new_sel;
    logic [8:0]              drop_sum;

    // Roll is the number of partition thresholds reached; a compare chain avoids a divider.
    function automatic logic [2:0] addr_roll(input logic [10:0] a);
        logic [2:0] r;
        r = '0;
        for (int t = 1; t < 8; t++)
            if (a >= 11'(t * PADS_PER_ROLL)) r = r + 3'd1;
        return r;
    endfunction

    function automatic logic [7:0] addr_pad(input logic [10:0] a);
        logic [10:0] base;
        logic [10:0] diff;
        base = 11'(addr_roll(a)) * 11'(PADS_PER_ROLL);
        diff = a - base;
        return diff[7:0];
    endfunction

    function automatic logic [2:0] first_idx(input logic [MXCLUSTERS-1:0] m);
        logic [2:0] r;
        r = '0;
        for (int k = MXCLUSTERS - 1; k >= 0; k--)
            if (m[k]) r = 3'(k);
        return r;
    endfunction

    function automatic logic [3:0] popcount(input logic [MXCLUSTERS-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < MXCLUSTERS; k++)
            r = r + 4'(m[k]);
        return r;
    endfunction

    always_comb begin
        new_mask = '0;
        for (int k = 0; k < MXCLUSTERS; k++) begin
            in_word[k]  = clusters_in[14*k +: 14];
`ifdef GEM_SEQ_ROLL_FILTER_EN
            new_mask[k] = (in_word[k][10:0] <= MAXADR) && roll_mask[addr_roll(in_word[k][10:0])];
`else
            new_mask[k] = (in_word[k][10:0] <= MAXADR);
`endif
        end
    end

    always_comb begin
        lat_idx  = first_idx(pending);
        new_idx  = first_idx(new_mask);
        lat_sel  = lat_word[lat_idx];
        new_sel  = in_word[new_idx];
        drop_sum = {1'b0, ndropped} + 9'(popcount(pending));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pending        <= '0;
            for (int k = 0; k < MXCLUSTERS; k++) lat_word[k] <= '0;
            cluster0       <= '0;
            cluster0_vpf   <= 1'b0;
            cluster0_roll  <= '0;
            cluster0_pad   <= '0;
            cluster0_size  <= '0;
            cluster0_index <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overrun        <= 1'b0;
            ndropped       <= '0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            if (bx_strobe) begin
                for (int k = 0; k < MXCLUSTERS; k++) lat_word[k] <= in_word[k];
                state <= ISSUE;
                busy  <= 1'b1;
                if (state == ISSUE && pending != '0) begin
                    // Aborting a live sequence: the new BX starts issuing on this same edge.
                    overrun  <= 1'b1;
                    ndropped <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
                    pending  <= new_mask & (new_mask - 1'b1);
                    if (new_mask != '0) begin
                        cluster0       <= new_sel;
                        cluster0_vpf   <= 1'b1;
                        cluster0_roll  <= addr_roll(new_sel[10:0]);
                        cluster0_pad   <= addr_pad(new_sel[10:0]);
                        cluster0_size  <= new_sel[13:11];
                        cluster0_index <= new_idx;
                    end else begin
                        cluster0_vpf   <= 1'b0;
                    end
                end else begin
                    pending      <= new_mask;
                    cluster0_vpf <= 1'b0;
                end
            end else if (state == ISSUE) begin
                if (pending != '0) begin
                    pending        <= pending & (pending - 1'b1);
                    cluster0       <= lat_sel;
                    cluster0_vpf   <= 1'b1;
                    cluster0_roll  <= addr_roll(lat_sel[10:0]);
                    cluster0_pad   <= addr_pad(lat_sel[10:0]);
                    cluster0_size  <= lat_sel[13:11];
                    cluster0_index <= lat_idx;
                end else begin
                    cluster0_vpf <= 1'b0;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_gem_cluster_sequencer.sv
// Bench for gem_cluster_sequencer: directed and random BX strobes against a queue-based reference model.
module tb_gem_cluster_sequencer;

    logic         clock;
    logic         reset_n;
    logic         bx_strobe;
    logic [111:0] clusters_in;
    logic [7:0]   roll_mask;
    logic [13:0]  cluster0;
    logic         cluster0_vpf;
    logic [2:0]   cluster0_roll;
    logic [7:0]   cluster0_pad;
    logic [2:0]   cluster0_size;
    logic [2:0]   cluster0_index;
    logic         busy;
    logic         done;
    logic         overrun;
    logic [7:0]   ndropped;

    int n_assert = 0;
    int n_fail   = 0;

    gem_cluster_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bx_strobe      (bx_strobe),
        .clusters_in    (clusters_in),
`ifdef GEM_SEQ_ROLL_FILTER_EN
        .roll_mask      (roll_mask),
`endif
        .cluster0       (cluster0),
        .cluster0_vpf   (cluster0_vpf),
        .cluster0_roll  (cluster0_roll),
        .cluster0_pad   (cluster0_pad),
        .cluster0_size  (cluster0_size),
        .cluster0_index (cluster0_index),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun),
        .ndropped       (ndropped)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    // Reference model: sequence as a queue of slot numbers, decode by plain division.
    int          q[$];
    logic [13:0] m_words [8];
    logic        m_busy;
    logic [13:0] m_cluster;
    logic        m_vpf;
    logic [2:0]  m_roll;
    logic [7:0]  m_pad;
    logic [2:0]  m_size;
    logic [2:0]  m_index;
    logic        m_done;
    logic        m_overrun;
    int          m_ndropped;

    function automatic logic [13:0] mk(input int size, input int addr);
        logic [13:0] w;
        w = {3'(size), 11'(addr)};
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 8; k++) m_words[k] = '0;
        m_busy = 0; m_cluster = '0; m_vpf = 0; m_roll = '0; m_pad = '0;
        m_size = '0; m_index = '0; m_done = 0; m_overrun = 0; m_ndropped = 0;
    endtask

    task automatic model_issue(input int k);
        int a;
        a = int'(m_words[k][10:0]);
        m_cluster = m_words[k];
        m_vpf     = 1'b1;
        m_roll    = 3'(a / 192);
        m_pad     = 8'(a % 192);
        m_size    = m_words[k][13:11];
        m_index   = 3'(k);
    endtask

    task automatic model_edge(input logic stb, input logic [111:0] w, input logic [7:0] rm);
        int newq[$];
        int a;
        m_done = 0;
        m_overrun = 0;
        if (stb) begin
            for (int k = 0; k < 8; k++) begin
                a = int'(w[14*k +: 11]);
`ifdef GEM_SEQ_ROLL_FILTER_EN
                if (a <= 1535 && rm[a / 192]) newq.push_back(k);
`else
                if (a <= 1535 && rm != 8'h00) newq.push_back(k);
`endif
            end
            for (int k = 0; k < 8; k++) m_words[k] = w[14*k +: 14];
            if (m_busy && q.size() > 0) begin
                m_overrun  = 1;
                m_ndropped = m_ndropped + q.size();
                if (m_ndropped > 255) m_ndropped = 255;
                q = newq;
                if (q.size() > 0) model_issue(q.pop_front());
                else m_vpf = 0;
            end else begin
                q = newq;
                m_vpf = 0;
            end
            m_busy = 1;
        end else if (m_busy) begin
            if (q.size() > 0) model_issue(q.pop_front());
            else begin
                m_vpf = 0; m_done = 1; m_busy = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("cluster0", 32'(cluster0), 32'(m_cluster));
        chk("vpf", 32'(cluster0_vpf), 32'(m_vpf));
        chk("roll", 32'(cluster0_roll), 32'(m_roll));
        chk("pad", 32'(cluster0_pad), 32'(m_pad));
        chk("size", 32'(cluster0_size), 32'(m_size));
        chk("index", 32'(cluster0_index), 32'(m_index));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        chk("ndropped", 32'(ndropped), 32'(m_ndropped));
    endtask

    task automatic step(input logic stb, input logic [111:0] w);
        bx_strobe   = stb;
        clusters_in = w;
        @(posedge clock);
        model_edge(stb, w, roll_mask);
        #1;
        check_all();
        bx_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, clusters_in);
    endtask

    function automatic logic [111:0] all_invalid();
        logic [111:0] w;
        for (int k = 0; k < 8; k++) w[14*k +: 14] = mk(0, 2047);
        return w;
    endfunction

    function automatic logic [111:0] all_valid_rand();
        logic [111:0] w;
        for (int k = 0; k < 8; k++) w[14*k +: 14] = mk($urandom_range(0, 7), $urandom_range(0, 1535));
        return w;
    endfunction

    logic [111:0] w;

    initial begin
        reset_n     = 1'b0;
        bx_strobe   = 1'b0;
        clusters_in = '0;
        roll_mask   = 8'hFF;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        check_all();
        #2 reset_n = 1'b1;
        idle(2);

        // Two valid clusters, slots 0 and 3.
        w = all_invalid();
        w[13:0]  = mk(2, 0);
        w[55:42] = mk(0, 1535);
        step(1'b1, w);
        step(1'b0, w);
        chk("t1_index0", 32'(cluster0_index), 32'd0);
        chk("t1_size0", 32'(cluster0_size), 32'd2);
        step(1'b0, w);
        chk("t1_index3", 32'(cluster0_index), 32'd3);
        chk("t1_roll7", 32'(cluster0_roll), 32'd7);
        chk("t1_pad191", 32'(cluster0_pad), 32'd191);
        step(1'b0, w);
        chk("t1_done", 32'(done), 32'd1);
        idle(2);

        // Roll boundary decode.
        w = all_invalid();
        w[13:0]  = mk(1, 191);
        w[27:14] = mk(3, 192);
        w[41:28] = mk(5, 383);
        w[55:42] = mk(7, 1344);
        step(1'b1, w);
        step(1'b0, w);
        chk("t2_pad191", 32'(cluster0_pad), 32'd191);
        step(1'b0, w);
        chk("t2_roll1", 32'(cluster0_roll), 32'd1);
        chk("t2_pad0", 32'(cluster0_pad), 32'd0);
        step(1'b0, w);
        step(1'b0, w);
        chk("t2_roll7", 32'(cluster0_roll), 32'd7);
        idle(3);

        // All slots invalid: busy for exactly one cycle.
        step(1'b1, all_invalid());
        chk("t3_busy", 32'(busy), 32'd1);
        step(1'b0, all_invalid());
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy_clr", 32'(busy), 32'd0);
        idle(2);

        // Strobe on the edge where done would pulse: strobe wins.
        w = all_invalid();
        w[41:28] = mk(4, 700);
        step(1'b1, w);
        step(1'b0, w);
        step(1'b1, all_valid_rand());
        chk("t4_no_done", 32'(done), 32'd0);
        chk("t4_no_overrun", 32'(overrun), 32'd0);
        idle(12);

        // Asynchronous reset in the middle of a sequence.
        w = all_invalid();
        for (int k = 0; k < 5; k++) w[14*k +: 14] = mk($urandom_range(0, 7), $urandom_range(0, 1535));
        step(1'b1, w);
        step(1'b0, w);
        step(1'b0, w);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        #2 reset_n = 1'b1;
        idle(6);

        // Back-to-back overruns until ndropped saturates.
        for (int it = 0; it < 60; it++) begin
            step(1'b1, all_valid_rand());
            if (it == 1) begin
                chk("t5_overrun", 32'(overrun), 32'd1);
                chk("t5_ndropped6", 32'(ndropped), 32'd6);
            end
            step(1'b0, clusters_in);
            step(1'b0, clusters_in);
        end
        idle(12);
        chk("t5_saturated", 32'(ndropped), 32'd255);

`ifdef GEM_SEQ_ROLL_FILTER_EN
        roll_mask = 8'h01;
        w = all_invalid();
        w[13:0]  = mk(0, 10);
        w[27:14] = mk(0, 200);
        w[41:28] = mk(0, 100);
        step(1'b1, w);
        roll_mask = 8'h00;
        step(1'b0, w);
        chk("t6_first", 32'(cluster0_index), 32'd0);
        step(1'b0, w);
        chk("t6_second", 32'(cluster0_index), 32'd2);
        step(1'b0, w);
        chk("t6_done", 32'(done), 32'd1);
        roll_mask = 8'hFF;
        idle(2);
`endif

        // Random strobes with mixed valid/invalid addresses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int k = 0; k < 8; k++) w[14*k +: 14] = mk($urandom_range(0, 7), $urandom_range(0, 2047));
`ifdef GEM_SEQ_ROLL_FILTER_EN
                roll_mask = 8'($urandom_range(0, 255));
`endif
                step(1'b1, w);
            end else begin
                step(1'b0, clusters_in);
            end
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
